// File: rtl/ecpri_tx_resp.sv
// eCPRI RMA (type 4) response framer: serialises read/write responses onto a byte stream, read payload fetched from data memory.
// Latency: a strobe seen in IDLE produces the first header byte on the next cycle; data bytes arrive at most one per 3 cycles.
// Backpressure: tx_ready low holds tx_byte/tx_sof/tx_eof and the FSM; optional counters enabled by ECPRI_TX_STATS_EN.
module ecpri_tx_resp #(
  parameter logic [15:0] ELEMENT_ID = 16'h0001,
  parameter logic [3:0]  REVISION   = 4'h1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        send_write_resp,
  input  logic        send_read_resp,
  input  logic [7:0]  info_to_tx,
  input  logic [7:0]  tx_payload_len,
  input  logic [7:0]  req_addr,
  output logic        mem_rd_en,
  output logic [7:0]  mem_rd_addr,
  input  logic [7:0]  mem_rd_data,
  output logic [7:0]  tx_byte,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_sof,
  output logic        tx_eof,
  output logic        busy
`ifdef ECPRI_TX_STATS_EN
  ,
  output logic [15:0] rd_resp_cnt,
  output logic [15:0] wr_resp_cnt,
  output logic [7:0]  drop_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, HDR, MEM_REQ, MEM_WAIT, DATA} state_t;

  state_t      state_q, state_d;

  // pending request slots
  logic        rd_pend_q, rd_pend_d;
  logic [7:0]  rd_id_q, rd_id_d;
  logic [7:0]  rd_len_q, rd_len_d;
  logic [7:0]  rd_addr_q, rd_addr_d;
  logic        wr_pend_q, wr_pend_d;
  logic [7:0]  wr_id_q, wr_id_d;
  logic [7:0]  wr_addr_q, wr_addr_d;

  // context of the frame being sent
  logic        cur_rd_q, cur_rd_d;
  logic [7:0]  cur_id_q, cur_id_d;
  logic [7:0]  cur_len_q, cur_len_d;
  logic [7:0]  cur_addr_q, cur_addr_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  data_q, data_d;

  // A strobe in the same cycle counts as pending so an idle framer starts immediately;
  // its fresh context beats any older slot contents (last request wins).
  logic        rd_avail, wr_avail;
  logic [7:0]  eff_rd_id, eff_rd_len, eff_rd_addr, eff_wr_id, eff_wr_addr;
  logic        has_data;
  logic [15:0] psize;
  logic [7:0]  hdr_byte;

  assign rd_avail    = rd_pend_q | send_read_resp;
  assign wr_avail    = wr_pend_q | send_write_resp;
  assign eff_rd_id   = send_read_resp  ? info_to_tx     : rd_id_q;
  assign eff_rd_len  = send_read_resp  ? tx_payload_len : rd_len_q;
  assign eff_rd_addr = send_read_resp  ? req_addr       : rd_addr_q;
  assign eff_wr_id   = send_write_resp ? info_to_tx     : wr_id_q;
  assign eff_wr_addr = send_write_resp ? req_addr       : wr_addr_q;
  assign has_data    = cur_rd_q && (cur_len_q != 8'd0);
  assign psize       = 16'd12 + {8'h00, (cur_rd_q ? cur_len_q : 8'h00)};
  assign busy        = (state_q != IDLE) || rd_pend_q || wr_pend_q;

  // header byte selected by position within the 16-byte header
  always_comb begin
    hdr_byte = 8'h00;
    case (idx_q)
      4'd0:    hdr_byte = {REVISION, 3'b000, 1'b0};
      4'd1:    hdr_byte = 8'h04;
      4'd2:    hdr_byte = psize[15:8];
      4'd3:    hdr_byte = psize[7:0];
      4'd4:    hdr_byte = cur_id_q;
      4'd5:    hdr_byte = cur_rd_q ? 8'h01 : 8'h11;
      4'd6:    hdr_byte = ELEMENT_ID[15:8];
      4'd7:    hdr_byte = ELEMENT_ID[7:0];
      4'd13:   hdr_byte = cur_addr_q;
      4'd14:   hdr_byte = 8'h00;
      4'd15:   hdr_byte = cur_rd_q ? cur_len_q : 8'h00;
      default: hdr_byte = 8'h00;
    endcase
  end

  // next-state, request capture/arbitration and stream outputs
  always_comb begin
    state_d     = state_q;
    rd_pend_d   = rd_avail;
    rd_id_d     = eff_rd_id;
    rd_len_d    = eff_rd_len;
    rd_addr_d   = eff_rd_addr;
    wr_pend_d   = wr_avail;
    wr_id_d     = eff_wr_id;
    wr_addr_d   = eff_wr_addr;
    cur_rd_d    = cur_rd_q;
    cur_id_d    = cur_id_q;
    cur_len_d   = cur_len_q;
    cur_addr_d  = cur_addr_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    tx_valid    = 1'b0;
    tx_byte     = 8'h00;
    tx_sof      = 1'b0;
    tx_eof      = 1'b0;
    mem_rd_en   = 1'b0;
    mem_rd_addr = 8'h00;

    case (state_q)
      IDLE: begin
        idx_d = 4'd0;
        cnt_d = 8'd0;
        if (rd_avail) begin
          state_d    = HDR;
          rd_pend_d  = 1'b0;
          cur_rd_d   = 1'b1;
          cur_id_d   = eff_rd_id;
          cur_len_d  = eff_rd_len;
          cur_addr_d = eff_rd_addr;
        end else if (wr_avail) begin
          state_d    = HDR;
          wr_pend_d  = 1'b0;
          cur_rd_d   = 1'b0;
          cur_id_d   = eff_wr_id;
          cur_len_d  = 8'd0;
          cur_addr_d = eff_wr_addr;
        end
      end
      HDR: begin
        tx_valid = 1'b1;
        tx_byte  = hdr_byte;
        tx_sof   = (idx_q == 4'd0);
        tx_eof   = (idx_q == 4'd15) && !has_data;
        if (tx_ready) begin
          if (idx_q == 4'd15) begin
            state_d = has_data ? MEM_REQ : IDLE;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      MEM_REQ: begin
        mem_rd_en   = 1'b1;
        mem_rd_addr = cur_addr_q + cnt_q;
        state_d     = MEM_WAIT;
      end
      MEM_WAIT: begin
        data_d  = mem_rd_data;
        state_d = DATA;
      end
      DATA: begin
        tx_valid = 1'b1;
        tx_byte  = data_q;
        tx_eof   = (cnt_q == (cur_len_q - 8'd1));
        if (tx_ready) begin
          if (tx_eof) begin
            state_d = IDLE;
          end else begin
            cnt_d   = cnt_q + 8'd1;
            state_d = MEM_REQ;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and context registers; reset aborts any frame in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rd_pend_q  <= 1'b0;
      rd_id_q    <= 8'h00;
      rd_len_q   <= 8'h00;
      rd_addr_q  <= 8'h00;
      wr_pend_q  <= 1'b0;
      wr_id_q    <= 8'h00;
      wr_addr_q  <= 8'h00;
      cur_rd_q   <= 1'b0;
      cur_id_q   <= 8'h00;
      cur_len_q  <= 8'h00;
      cur_addr_q <= 8'h00;
      idx_q      <= 4'd0;
      cnt_q      <= 8'd0;
      data_q     <= 8'h00;
    end else begin
      state_q    <= state_d;
      rd_pend_q  <= rd_pend_d;
      rd_id_q    <= rd_id_d;
      rd_len_q   <= rd_len_d;
      rd_addr_q  <= rd_addr_d;
      wr_pend_q  <= wr_pend_d;
      wr_id_q    <= wr_id_d;
      wr_addr_q  <= wr_addr_d;
      cur_rd_q   <= cur_rd_d;
      cur_id_q   <= cur_id_d;
      cur_len_q  <= cur_len_d;
      cur_addr_q <= cur_addr_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
    end
  end

`ifdef ECPRI_TX_STATS_EN
  logic [15:0] rd_cnt_q, wr_cnt_q;
  logic [7:0]  drop_q;
  logic        eof_xfer, rd_drop, wr_drop;

  assign eof_xfer    = tx_valid && tx_ready && tx_eof;
  assign rd_drop     = send_read_resp && rd_pend_q;
  assign wr_drop     = send_write_resp && wr_pend_q;
  assign rd_resp_cnt = rd_cnt_q;
  assign wr_resp_cnt = wr_cnt_q;
  assign drop_cnt    = drop_q;

  // completed-frame and overwritten-request counters, free-running with wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_cnt_q <= 16'd0;
      wr_cnt_q <= 16'd0;
      drop_q   <= 8'd0;
    end else begin
      if (eof_xfer && cur_rd_q)  rd_cnt_q <= rd_cnt_q + 16'd1;
      if (eof_xfer && !cur_rd_q) wr_cnt_q <= wr_cnt_q + 16'd1;
      drop_q <= drop_q + {7'd0, rd_drop} + {7'd0, wr_drop};
    end
  end
`endif

endmodule
